// File: rtl/mandel_pkg.sv
// Shared widths, Q4.28 constants and FSM state encoding for the Mandelbrot escape-time core.
package mandel_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 28;
  localparam int ITER_W = 13;

  localparam logic signed [DATA_W-1:0] FX_ONE       = DATA_W'(1) <<< FRAC_W;
  localparam logic signed [DATA_W-1:0] FX_FOUR      = DATA_W'(4) <<< FRAC_W;
  localparam logic signed [DATA_W-1:0] FX_QUARTER   = DATA_W'(1) <<< (FRAC_W - 2);
  localparam logic signed [DATA_W-1:0] FX_SIXTEENTH = DATA_W'(1) <<< (FRAC_W - 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mandel_iter_core_fx_mul.sv
// Signed W x W multiplier returning the full 2W-bit product.
module fx_mul #(
  parameter int W = 32
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mandel_iter_core.sv
// Per-pixel Mandelbrot escape-time engine, one z^2+c iteration per clock.
// Optional MANDEL_INTERIOR_CHECK_EN adds a one-cycle bulb/cardioid interior test.
module mandel_iter_core
  import mandel_pkg::*;
#(
  parameter int DATA_W = mandel_pkg::DATA_W,
  parameter int FRAC_W = mandel_pkg::FRAC_W,
  parameter int ITER_W = mandel_pkg::ITER_W
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_im,
  input  logic        [ITER_W-1:0] max_iter,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic        [ITER_W-1:0] res_count,
  output logic                     res_escaped
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW:0] ESC_LIM = (PW + 1)'(FX_FOUR) <<< FRAC_W;

  state_t                   state;
  logic signed [DATA_W-1:0] zr, zi, cr, ci;
  logic        [ITER_W-1:0] k, lim;

  logic signed [DATA_W-1:0] ma0, ma1, ma2a, ma2b;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri;
  logic signed [PW:0]       mag, diff;
  logic signed [DATA_W-1:0] zr_next, zi_next;
  logic                     escape;

  // During CHECK the three squarers are borrowed for (cr+1)^2, ci^2 and (cr-1/4)^2.
  always_comb begin
    ma0  = zr;
    ma1  = zi;
    ma2a = zr;
    ma2b = zi;
`ifdef MANDEL_INTERIOR_CHECK_EN
    if (state == CHECK) begin
      ma0  = cr + FX_ONE;
      ma1  = ci;
      ma2a = cr - FX_QUARTER;
      ma2b = cr - FX_QUARTER;
    end
`endif
  end

  fx_mul #(.W(DATA_W)) u_mul_rr (.a(ma0),  .b(ma0),  .p(p_rr));
  fx_mul #(.W(DATA_W)) u_mul_ii (.a(ma1),  .b(ma1),  .p(p_ii));
  fx_mul #(.W(DATA_W)) u_mul_ri (.a(ma2a), .b(ma2b), .p(p_ri));

  assign mag     = (PW + 1)'(p_rr) + (PW + 1)'(p_ii);
  assign diff    = (PW + 1)'(p_rr) - (PW + 1)'(p_ii);
  assign escape  = (mag >= ESC_LIM);
  assign zr_next = DATA_W'(diff >>> FRAC_W) + cr;
  // Doubling folded into the narrowing shift.
  assign zi_next = DATA_W'(p_ri >>> (FRAC_W - 1)) + ci;

`ifdef MANDEL_INTERIOR_CHECK_EN
  localparam int QW = PW + 1 - FRAC_W;
  localparam logic signed [PW:0] BULB_LIM = (PW + 1)'(FX_SIXTEENTH) <<< FRAC_W;

  logic signed [PW:0]     q_full;
  logic signed [QW-1:0]   q, q_t;
  logic signed [2*QW-1:0] p_q, ci_sq_qtr;
  logic                   interior;

  assign q_full    = (PW + 1)'(p_ri) + (PW + 1)'(p_ii);
  assign q         = QW'(q_full >>> FRAC_W);
  assign q_t       = q + QW'(cr) - QW'(FX_QUARTER);
  assign ci_sq_qtr = (2 * QW)'(p_ii >>> 2);

  fx_mul #(.W(QW)) u_mul_q (.a(q), .b(q_t), .p(p_q));

  assign interior = (mag < BULB_LIM) || (p_q < ci_sq_qtr);
`endif

  assign start_ready = (state == IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      res_valid   <= 1'b0;
      res_count   <= '0;
      res_escaped <= 1'b0;
      zr          <= '0;
      zi          <= '0;
      k           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            cr  <= c_re;
            ci  <= c_im;
            lim <= max_iter;
            zr  <= '0;
            zi  <= '0;
            k   <= '0;
`ifdef MANDEL_INTERIOR_CHECK_EN
            state <= CHECK;
`else
            state <= ITER;
`endif
          end
        end
`ifdef MANDEL_INTERIOR_CHECK_EN
        CHECK: begin
          if (interior) begin
            res_count   <= lim;
            res_escaped <= 1'b0;
            res_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            state <= ITER;
          end
        end
`endif
        ITER: begin
          if (escape) begin
            res_count   <= k;
            res_escaped <= 1'b1;
            res_valid   <= 1'b1;
            state       <= DONE;
          end else if (k == lim) begin
            res_count   <= k;
            res_escaped <= 1'b0;
            res_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            zr <= zr_next;
            zi <= zi_next;
            k  <= k + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_core.sv
// Scoreboard bench for mandel_iter_core: driver pushes expected results, monitor pops on res_valid.
module tb_mandel_iter_core;

  logic        clock;
  logic        resetn;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] c_re;
  logic [31:0] c_im;
  logic [12:0] max_iter;
  logic        res_valid;
  logic        res_ready;
  logic [12:0] res_count;
  logic        res_escaped;

  mandel_iter_core dut (
    .clock       (clock),
    .resetn      (resetn),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .c_re        (c_re),
    .c_im        (c_im),
    .max_iter    (max_iter),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_count   (res_count),
    .res_escaped (res_escaped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {
    int cnt;
    bit esc;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   last_valid_cycle = 0;
  bit   prev_valid = 1'b0;

  localparam logic [31:0] C_ZERO  = 32'h0000_0000;
  localparam logic [31:0] C_ONE   = 32'h1000_0000;
  localparam logic [31:0] C_HALF  = 32'h0800_0000;
  localparam logic [31:0] C_M_ONE = 32'hF000_0000;
  localparam logic [31:0] C_M_TEN = 32'hFE66_6667;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
  endtask

  // Latency of a result that runs through ITER with the given count.
  function automatic int lat_iter(input int cnt);
`ifdef MANDEL_INTERIOR_CHECK_EN
    return cnt + 2;
`else
    return cnt + 1;
`endif
  endfunction

  always @(negedge clock) begin
    if (resetn && res_valid && !prev_valid) begin
      last_valid_cycle = cycle;
      if (sb.size() == 0) begin
        chk("spurious_result", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("res_count", res_count, mon_e.cnt);
        chk("res_escaped", res_escaped, mon_e.esc);
        chk("latency_edge", cycle, mon_e.due);
      end
    end
    prev_valid = res_valid;
  end

  task automatic issue(input logic [31:0] cr, input logic [31:0] ci, input logic [12:0] mi,
                       input int exp_cnt, input bit exp_esc, input int exp_lat,
                       output int acc);
    int n;
    @(negedge clock);
    start_valid = 1'b1;
    c_re        = cr;
    c_im        = ci;
    max_iter    = mi;
    n = 0;
    while (!start_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!start_ready) begin
      chk("accept_timeout", n, 0);
      start_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cycle + 1;
    sb.push_back('{cnt: exp_cnt, esc: exp_esc, due: acc + exp_lat});
    @(posedge clock);
    #1;
    start_valid = 1'b0;
    c_re        = $urandom;
    c_im        = $urandom;
    max_iter    = 13'($urandom);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || !start_ready) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0 || !start_ready) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int acc1, acc2, n;
    resetn      = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    c_re        = '0;
    c_im        = '0;
    max_iter    = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_start_ready", start_ready, 1);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_count", res_count, 0);
    chk("reset_res_escaped", res_escaped, 0);
    @(negedge clock);
    resetn = 1'b1;

`ifdef MANDEL_INTERIOR_CHECK_EN
    issue(C_ZERO, C_ZERO, 13'd511, 511, 1'b0, 1, acc1);
`else
    issue(C_ZERO, C_ZERO, 13'd511, 511, 1'b0, 512, acc1);
`endif
    issue(C_ONE,  C_ZERO, 13'd100,  2,   1'b1, lat_iter(2),   acc1);
    issue(C_HALF, C_ZERO, 13'd1023, 5,   1'b1, lat_iter(5),   acc1);
    issue(C_ZERO, C_ONE,  13'd255,  255, 1'b0, lat_iter(255), acc1);
    issue(C_HALF, C_ZERO, 13'd0,    0,   1'b0, lat_iter(0),   acc1);

    // Back-to-back with res_ready held high: one idle edge between DONE and the next accept.
    drain();
    issue(C_ZERO, C_ZERO, 13'd0, 0, 1'b0, 1, acc1);
    issue(C_ZERO, C_ZERO, 13'd0, 0, 1'b0, 1, acc2);
    chk("b2b_accept_gap", acc2 - last_valid_cycle, 2);
    drain();

    // Backpressure: result must hold while inputs churn.
    res_ready = 1'b0;
    issue(C_ONE, C_ZERO, 13'd100, 2, 1'b1, lat_iter(2), acc1);
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("bp_valid_seen", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      start_valid = ~start_valid;
      c_re        = $urandom;
      c_im        = $urandom;
      max_iter    = 13'($urandom);
      #1;
      chk("bp_start_ready", start_ready, 0);
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_count", res_count, 2);
      chk("bp_res_escaped", res_escaped, 1);
    end
    @(negedge clock);
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    chk("bp_release_ready", start_ready, 1);
    chk("bp_release_valid", res_valid, 0);
    res_ready = 1'b1;
    issue(C_HALF, C_ZERO, 13'd1023, 5, 1'b1, lat_iter(5), acc1);
    drain();

    // Reset while iterating: the abandoned request must not produce a result.
    issue(C_ZERO, C_ONE, 13'd255, 255, 1'b0, lat_iter(255), acc1);
    repeat (100) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    void'(sb.pop_back());
    @(posedge clock);
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_count", res_count, 0);
    chk("midrst_start_ready", start_ready, 1);
    @(negedge clock);
    resetn = 1'b1;
    repeat (300) @(negedge clock);
    issue(C_ONE, C_ZERO, 13'd100, 2, 1'b1, lat_iter(2), acc1);

`ifdef MANDEL_INTERIOR_CHECK_EN
    issue(C_M_ONE, C_ZERO, 13'd77,  77,  1'b0, 1, acc1);
    issue(C_M_TEN, C_ZERO, 13'd300, 300, 1'b0, 1, acc1);
    issue(C_ONE,   C_ZERO, 13'd100, 2,   1'b1, 4, acc1);
`endif

    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mandel_iter_core.md
Name: mandel_iter_core

Overview:
- Per-pixel Mandelbrot escape-time engine.
- Consumes the 13-bit maximum-iteration value from the keyboard iteration selector, plus one complex coordinate c per request from the pixel scanner.
- Iterates z(k+1) = z(k)^2 + c in signed fixed point, one iteration per clock.
- Returns the escape count to the colour mapper over a valid/ready result handshake.

Parameters:
DATA_W, 32, total width of each fixed-point component (signed)
FRAC_W, 28, fractional bits (Q4.28; 1.0 = 0x1000_0000)
ITER_W, 13, width of max_iter and res_count

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
start_valid  in  1  request present
start_ready  out  1  core idle, can accept request
c_re  in  DATA_W  real part of c, signed Q4.28
c_im  in  DATA_W  imaginary part of c, signed Q4.28
max_iter  in  ITER_W  iteration limit, sampled at accept
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_count  out  ITER_W  iterations completed
res_escaped  out  1  1 = escaped, 0 = limit reached

Behaviour:
- Reset: resetn low at a rising edge forces state IDLE, res_valid=0, res_count=0, res_escaped=0, z=0, k=0. This takes priority over all other activity, including mid-ITER; an abandoned request produces no result.
- States: IDLE, ITER, DONE. start_ready = (state==IDLE), decoded combinationally.
- IDLE: on start_valid&&start_ready at edge E0, latch c_re, c_im and max_iter, clear z and k, go to ITER. Later input changes are ignored until the next accept.
- ITER, each cycle, checks in this priority order:
  - (a) If zr^2+zi^2 >= 4.0: res_count=k, res_escaped=1, go to DONE.
  - (b) Else if k==max_iter: res_count=k, res_escaped=0, go to DONE.
  - (c) Else: zr <= zr^2-zi^2+cr, zi <= 2*zr*zi+ci, k <= k+1.
- Latency: res_valid is registered at edge E0+(res_count+1).
- DONE: res_valid=1; res_count and res_escaped held stable while res_ready=0. When res_ready=1 at an edge, clear res_valid and go to IDLE. No new accept can happen in that same edge; the earliest next accept is the following edge.
- Arithmetic:
  - Products are full 2*DATA_W signed.
  - The escape sum is compared at full precision (2*DATA_W+1 bits) against 4.0<<FRAC_W.
  - z update narrows by arithmetic right shift of FRAC_W, truncating toward -inf.
  - 2*zr*zi is done as a shift, not a multiplier.
  - With |c|<4 and |z|<2 before an update, no overflow occurs. Inputs with |c_re| or |c_im| >= 4.0 are unsupported.
- Boundaries:
  - max_iter=0 gives count 0, escaped 0, latency 1.
  - |z|^2 exactly 4.0 counts as escaped.
  - k never exceeds max_iter, so the max_iter=8191 limit needs no wrap.

Optional Feature:
- Macro: MANDEL_INTERIOR_CHECK_EN.
- Enabled: adds state CHECK, entered from IDLE on accept and lasting 1 cycle.
  - If c is in the period-2 bulb, (cr+1)^2+ci^2 < 1/16, or in the main cardioid, q*(q+cr-1/4) < ci^2/4 with q=(cr-1/4)^2+ci^2, go to DONE with res_count=max_iter, res_escaped=0. Latency is 1 edge.
  - Otherwise go to ITER; all ITER latencies grow by +1.
- Disabled: no CHECK state; IDLE goes directly to ITER; the extra multipliers are not built.

Decomposition:
- Package mandel_pkg:
  - DATA_W, FRAC_W, ITER_W defaults.
  - Fixed-point constants FX_ONE, FX_FOUR, FX_QUARTER, FX_SIXTEENTH.
  - State enum (IDLE, CHECK, ITER, DONE).
- Sub-module fx_mul: signed DATA_W x DATA_W multiply returning the full-width product. Instantiated 3x for zr^2, zi^2 and zr*zi; the check logic reuses the same instances during CHECK.

Test Plan:
- c=0, max_iter=511 -> res_count=511, res_escaped=0, res_valid at E0+512.
- c=1.0 (c_re=0x1000_0000, c_im=0) -> z=0,1,2; res_count=2, escaped=1, latency 3 (exact-4.0 boundary).
- c=0.5 (0x0800_0000), max_iter=1023 -> res_count=5, escaped=1. c=0+1i (c_im=0x1000_0000), max_iter=255 -> count 255, escaped 0.
- max_iter=0, any c -> res_count=0, escaped=0 at E0+1. Back-to-back requests with res_ready tied 1 -> each accept waits one idle edge after DONE.
- Backpressure: hold res_ready=0 for 10 cycles while toggling max_iter, c and start_valid -> start_ready=0, results stable. Then pulse res_ready -> IDLE, next request accepted.
- Reset mid-operation: resetn=0 at k=100 -> next edge res_valid=0, res_count=0, start_ready=1, no spurious result. With MANDEL_INTERIOR_CHECK_EN: c=-1.0 and c=-0.1 -> count=max_iter, latency 1; c=1.0 -> latency 4.
